// File: rtl/ro_freq_counter.sv
// ro_freq_counter
//   Counts rising edges of a ring-oscillator signal over a programmable gate
//   window of wb_clk_i cycles. Frequency = count_o * f_clk / gate_cycles.
//   The oscillator input is asynchronous and is synchronized before edge
//   detection, so the measurable frequency must stay below f_clk/2.
//
// Ports
//   wb_clk_i       system clock, sole clock of the block
//   wb_rst_i       synchronous active-high reset
//   ro_in          asynchronous oscillator signal from the select mux
//   start_i        measurement request, level-sampled in IDLE and DONE
//   gate_cycles_i  window length N in clocks, latched when a start is accepted
//   count_o        edge count of the last completed measurement (held)
//   overflow_o     last measurement saturated the edge counter
//   done_o         one-cycle strobe, count_o/overflow_o just updated
//   busy_o         measurement in progress (ARM or GATE)
module ro_freq_counter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ro_in,
    input  logic              start_i,
    input  logic [GATE_W-1:0] gate_cycles_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              done_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ro_prev_q, ro_prev_d;
    logic [GATE_W-1:0]      n_q, n_d;
    logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic                   ro_s;
    logic                   rise;

    // Synchronizer shift chain and edge detector.
    assign ro_s = sync_q[SYNC_STAGES-1];
    assign rise = ro_s & ~ro_prev_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], ro_in};
        ro_prev_d = ro_s;
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_d     = gate_cycles_i;
                    state_d = ARM;
                end
            end

            ARM: begin
                // No counting here: the edge detector settles on the current
                // level, so a line already high never yields a false edge.
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                gate_cnt_d = n_q;
                if (n_q == '0) begin
                    state_d = DONE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = GATE;
                end
            end

            GATE: begin
                if (rise) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                gate_cnt_d = gate_cnt_q - GATE_W'(1);
                // Result is captured on the way into DONE so that it is
                // already visible while done_o is high; it includes an edge
                // seen in this final gate cycle.
                if (gate_cnt_q == GATE_W'(1)) begin
                    state_d = DONE;
                    count_d = edge_cnt_d;
                    ovf_d   = sat_d;
                end
            end

            DONE: begin
                if (start_i) begin
                    n_d     = gate_cycles_i;
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            ro_prev_q  <= 1'b0;
            n_q        <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            ro_prev_q  <= ro_prev_d;
            n_q        <= n_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign done_o     = (state_q == DONE);
    assign busy_o     = (state_q == ARM) || (state_q == GATE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: a default-width instance (dut0) and a
// 4-bit-counter instance (dut1) for saturation. Expected results are queued
// when a measurement is started and compared when done_o fires.
module tb_ro_freq_counter;

    logic        clk;
    logic        rst;
    logic        ro_in;
    logic        start0;
    logic        start1;
    logic [15:0] gate;

    logic [23:0] count0;
    logic        ovf0, done0, busy0;
    logic [3:0]  count1;
    logic        ovf1, done1, busy1;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_pass  = 0;
    int n_total = 0;

    int ro_half = 0;
    logic ro_hold = 1'b0;
    int ph = 0;

    ro_freq_counter #(.GATE_W(16), .CNT_W(24), .SYNC_STAGES(2)) dut0 (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .ro_in        (ro_in),
        .start_i      (start0),
        .gate_cycles_i(gate),
        .count_o      (count0),
        .overflow_o   (ovf0),
        .done_o       (done0),
        .busy_o       (busy0)
    );

    ro_freq_counter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut1 (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .ro_in        (ro_in),
        .start_i      (start1),
        .gate_cycles_i(gate),
        .count_o      (count1),
        .overflow_o   (ovf1),
        .done_o       (done1),
        .busy_o       (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator model: period 2*ro_half clocks, or a static level when 0.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ro_half == 0) begin
                ro_in = ro_hold;
                ph    = 0;
            end else begin
                ph = ph + 1;
                if (ph >= ro_half) begin
                    ph    = 0;
                    ro_in = ~ro_in;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
        n_total = n_total + 1;
        assert (obs >= lo && obs <= hi) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Scoreboard: every done strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            chk("sb0_pending", 64'(q0.size() > 0), 64'(1));
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk_range("sb0_count", 64'(count0), e.lo, e.hi);
                chk("sb0_ovf", 64'(ovf0), e.ovf);
            end
        end
        if (done1) begin
            chk("sb1_pending", 64'(q1.size() > 0), 64'(1));
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk_range("sb1_count", 64'(count1), e.lo, e.hi);
                chk("sb1_ovf", 64'(ovf1), e.ovf);
            end
        end
    end

    // One single-start measurement; called and returns 1 ns after a posedge.
    task automatic run_measure(input int sel, input int n, input int lo, input int hi,
                               input logic ovf, input string tag);
        exp_t        e;
        int          done_cyc;
        int          busy_cnt;
        logic        hold_ok;
        logic [63:0] pre;
        logic [63:0] cur;
        logic        b;
        logic        d;
        e.lo  = 64'(lo);
        e.hi  = 64'(hi);
        e.ovf = 64'(ovf);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        done_cyc = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        gate     = 16'(n);
        if (sel == 0) start0 = 1'b1;
        else          start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        pre = (sel == 0) ? 64'(count0) : 64'(count1);
        for (int c = 1; c <= n + 50; c++) begin
            @(negedge clk);
            b   = (sel == 0) ? busy0 : busy1;
            d   = (sel == 0) ? done0 : done1;
            cur = (sel == 0) ? 64'(count0) : 64'(count1);
            if (b) busy_cnt = busy_cnt + 1;
            if (b && cur != pre) hold_ok = 1'b0;
            if (d) begin
                done_cyc = c;
                break;
            end
        end
        chk({tag, "_done_lat"}, 64'(done_cyc), 64'(n + 2));
        chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(n + 1));
        chk({tag, "_hold"}, 64'(hold_ok), 64'(1));
        @(negedge clk);
        d = (sel == 0) ? done0 : done1;
        chk({tag, "_done_1cyc"}, 64'(d), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d[3];
        int nd;
        int nd2;
        exp_t e;

        rst     = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        gate    = 16'd0;
        ro_in   = 1'b0;
        ro_half = 1;

        // Reset with the oscillator toggling.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count0", 64'(count0), 64'(0));
        chk("rst_ovf0", 64'(ovf0), 64'(0));
        chk("rst_done0", 64'(done0), 64'(0));
        chk("rst_busy0", 64'(busy0), 64'(0));
        chk("rst_count1", 64'(count1), 64'(0));
        chk("rst_busy1", 64'(busy1), 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ro_half = 0;
        ro_hold = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run_measure(0, 10, 0, 0, 1'b0, "quiet_n10");

        // Nominal: period 8 over 800 clocks.
        ro_half = 4;
        repeat (10) @(posedge clk);
        #1;
        run_measure(0, 800, 99, 101, 1'b0, "nominal");

        // Zero-length window.
        run_measure(0, 0, 0, 0, 1'b0, "zero_n");

        // Line stuck high before start.
        ro_half = 0;
        ro_hold = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run_measure(0, 50, 0, 0, 1'b0, "stuck_hi");

        // Saturation on the 4-bit instance, then recovery.
        ro_half = 2;
        repeat (6) @(posedge clk);
        #1;
        run_measure(1, 100, 15, 15, 1'b1, "sat");
        run_measure(1, 20, 4, 6, 1'b0, "post_sat");

        // Back-to-back with start held; gate change during GATE of run 2.
        ro_half = 4;
        e.lo = 64'(1); e.hi = 64'(3); e.ovf = 64'(0);
        q0.push_back(e);
        q0.push_back(e);
        e.lo = 64'(2); e.hi = 64'(5);
        q0.push_back(e);
        gate   = 16'd16;
        start0 = 1'b1;
        nd     = 0;
        d[0] = 0; d[1] = 0; d[2] = 0;
        for (int c = 1; c <= 200 && nd < 3; c++) begin
            @(negedge clk);
            if (done0) begin
                d[nd] = c;
                nd    = nd + 1;
            end
            if (nd == 1 && c == d[0] + 6) gate = 16'd30;
            if (nd == 2 && c == d[1] + 3) start0 = 1'b0;
        end
        start0 = 1'b0;
        chk("b2b_count", 64'(nd), 64'(3));
        chk("b2b_interval1", 64'(d[1] - d[0]), 64'(18));
        chk("b2b_interval2", 64'(d[2] - d[1]), 64'(32));
        repeat (40) @(negedge clk);
        chk("b2b_idle", 64'(busy0), 64'(0));
        @(posedge clk);
        #1;

        // Prior result near 42, then reset during GATE.
        run_measure(0, 336, 41, 43, 1'b0, "prior42");
        gate   = 16'd100;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midgate_busy", 64'(busy0), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy0), 64'(0));
        chk("abort_done", 64'(done0), 64'(0));
        chk("abort_count", 64'(count0), 64'(0));
        chk("abort_ovf", 64'(ovf0), 64'(0));
        nd2 = 0;
        repeat (120) begin
            @(negedge clk);
            if (done0 || busy0) nd2 = nd2 + 1;
        end
        chk("abort_quiet", 64'(nd2), 64'(0));

        chk("sb0_drained", 64'(q0.size()), 64'(0));
        chk("sb1_drained", 64'(q1.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Measurement side of the ring-oscillator path. It samples the muxed oscillator output and counts its rising edges over a programmable gate window of wb_clk_i cycles.
- It returns a held edge count with a done strobe, so a ring oscillator's frequency is read as count × f_clk / gate_cycles.
- It sits after the 16:1 oscillator select mux and runs entirely in the wb_clk_i domain.
- The oscillator input is asynchronous and goes through a synchronizer. The measurable input frequency is below f_clk/2; faster oscillators must be pre-divided upstream.

Parameters:
- GATE_W, 16, width of the gate-window length input.
- CNT_W, 24, width of the edge counter and result.
- SYNC_STAGES, 2, flip-flop stages on ro_in before edge detection; legal range is ≥2.

Ports:
- wb_clk_i  input  1  system clock; sole clock of the block.
- wb_rst_i  input  1  reset, synchronous, active-high.
- ro_in  input  1  oscillator signal from the select mux; asynchronous.
- start_i  input  1  request a measurement; level-sampled each clock.
- gate_cycles_i  input  GATE_W  window length N in clocks; latched on accepted start.
- count_o  output  CNT_W  result of the last completed measurement; held.
- overflow_o  output  1  last measurement saturated.
- done_o  output  1  one-cycle strobe: count_o/overflow_o just updated.
- busy_o  output  1  measurement in progress (ARM or GATE).

Behaviour:
- Reset is synchronous and active-high on wb_clk_i. While wb_rst_i is high at a clock edge, the following are cleared:
  - state = IDLE;
  - count_o = 0, overflow_o = 0, done_o = 0, busy_o = 0;
  - synchronizer flops = 0, edge-detect previous = 0;
  - internal edge counter = 0, internal gate counter = 0.
- Reset asserted mid-measurement aborts it. No done_o is issued and the result is cleared to 0.
- Synchronizer: ro_in passes through SYNC_STAGES flops to give ro_s. Edge detection is rise = ro_s & ~ro_prev, with ro_prev registered every clock.
- State machine, one-hot or encoded: IDLE, ARM, GATE, DONE.
  - IDLE: start_i=1 at an edge latches N = gate_cycles_i and moves to ARM.
  - ARM: exactly one cycle. Clears the edge counter and loads the gate counter with N. Moves to GATE if N≠0, else to DONE with result 0. No edges are counted in ARM, so a level already high on ro_in never produces a false edge.
  - GATE: exactly N clocks. Every cycle with rise=1 increments the edge counter. The gate counter decrements each cycle, and on its last GATE cycle the state moves to DONE. An edge detected in the last GATE cycle is counted.
  - DONE: one cycle.
    - count_o is loaded with the edge counter and overflow_o with the saturation flag.
    - done_o = 1 in this cycle only.
    - Next state is IDLE. If start_i=1 in DONE, the next state is ARM and N is re-latched (back-to-back measurements).
- busy_o = 1 exactly in ARM and GATE. start_i is ignored in ARM and GATE, and gate_cycles_i changes there have no effect.
- Latency: with start accepted at edge k, the FSM is in ARM after k, in GATE from k+1 through k+N, and in DONE after k+N+1. done_o is high in the cycle following edge k+N+1.
- Saturation: the edge counter stops at 2^CNT_W−1, and the saturation flag sets on any rise while at the maximum. overflow_o reports the flag at DONE.
- Between DONE strobes, count_o and overflow_o hold their values and never change mid-measurement.
- Accuracy: ±1 edge, from synchronizer latency at the window boundaries. Input pulses narrower than one clock may be missed; this is a documented limitation, not an error.

Test Plan:
- Reset: drive wb_rst_i for 2 cycles with ro_in toggling → all outputs 0. Then start with N=10 and ro_in held at 0 → done_o after 12 cycles, count_o=0, overflow_o=0.
- Nominal: ro_in period 8 clocks (4 high/4 low), N=800, start pulsed 1 cycle → busy_o high for 801 cycles, single done_o, count_o in {99,100,101}, overflow_o=0.
- Zero window and stuck-high: N=0 → done_o one cycle after ARM, count_o=0. Then ro_in held at 1 before start with N=50 → count_o=0 (no false edge).
- Saturation: CNT_W=4, ro_in period 4 clocks, N=100 → count_o=15, overflow_o=1. The next run with N=20 gives count_o=5±1 and overflow_o=0.
- Start handling: start_i held high continuously with N=16 → back-to-back measurements, done_o every 18 cycles. A gate_cycles_i change mid-GATE is not applied until the next ARM.
- Reset mid-GATE: assert wb_rst_i at cycle 5 of N=100 after a prior result of 42 → no done_o, state IDLE, count_o=0, busy_o=0 on the next cycle.
